dror_dispatch_controller: RTL and testbench

- Next-generation DROR point-validation controller; sits between the point cache and an array of CORE_NUMBER validator cores.
- Fetches one base point per request from the cache and loads it into a free core.
- Collects each core's inlier/outlier verdict and streams the selected point indices through an internal FIFO with a valid/ready output.
- Adds over the previous controller: selectable emit mode, true backpressure, explicit start/done handshake, and parametrised index width and FIFO depth.

---
 rtl/dror_dispatch_controller.sv | 214 +++++++++++++++++++++
 tb/tb_dror_dispatch_controller.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dror_dispatch_controller.sv
// DROR point-validation dispatch controller.
// Fetches base points from the point cache one request at a time, loads each
// into the lowest free validator core, collects per-core verdicts (lowest busy
// core first) and streams the selected point indices through a FWFT FIFO.
module dror_dispatch_controller #(
  parameter int N           = 16,
  parameter int CORE_NUMBER = 4,
  parameter int IDX_W       = 32,
  parameter int FIFO_DEPTH  = 64,
  parameter int MODE        = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [IDX_W-1:0]       point_cloud_size,
  output logic                   pt_req_valid,
  output logic [IDX_W-1:0]       pt_req_idx,
  input  logic                   pt_rsp_valid,
  input  logic [N-1:0]           pt_rsp_x,
  input  logic [N-1:0]           pt_rsp_y,
  input  logic [N-1:0]           pt_rsp_z,
  output logic [CORE_NUMBER-1:0] core_load,
  output logic [N-1:0]           core_point_x,
  output logic [N-1:0]           core_point_y,
  output logic [N-1:0]           core_point_z,
  input  logic [CORE_NUMBER-1:0] core_inlier,
  input  logic [CORE_NUMBER-1:0] core_outlier,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDX_W-1:0]       out_idx,
  output logic                   busy,
  output logic                   done,
  output logic [IDX_W-1:0]       emit_count,
  output logic                   proto_err
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int CORE_W = (CORE_NUMBER > 1) ? $clog2(CORE_NUMBER) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  typedef enum logic [1:0] {C_FREE, C_RESERVED, C_LOADED, C_BUSY} core_state_t;

  state_t            state, state_nxt;
  core_state_t       core_st [CORE_NUMBER];
  logic [IDX_W-1:0]  idx_buf [CORE_NUMBER];
  logic [IDX_W-1:0]  size_q, next_idx, completed, req_idx_q, emit_q;
  logic              req_out, proto_q;
  logic [CORE_W-1:0] req_core;

  logic [IDX_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;

  logic              running, start_ok, dispatch, rsp_fire;
  logic              free_found, col_found, col_sel, col_both;
  logic [CORE_W-1:0] free_core, col_core;
  logic [CORE_NUMBER-1:0] sel_vec;
  logic              fifo_full, fifo_empty, push, pop, can_push;

  assign running    = (state == S_RUN);
  assign start_ok   = start && (state == S_IDLE || state == S_DONE);
  assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign pop        = !fifo_empty && out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign can_push   = !fifo_full || pop;
  // Both verdicts together count as outlier, so they are never an inlier pick.
  assign sel_vec    = (MODE == 0) ? core_outlier : (core_inlier & ~core_outlier);

  // Lowest-numbered FREE core is the next reservation target.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    free_found = 1'b0;
    free_core  = '0;
    for (int c = CORE_NUMBER - 1; c >= 0; c--) begin
      if (core_st[c] == C_FREE) begin
        free_found = 1'b1;
        free_core  = CORE_W'(c);
      end
    end
  end

  // Lowest-numbered BUSY core with a verdict that can be retired this cycle;
  // a selected verdict blocked by a full FIFO is skipped and stays pending.
  always_comb begin
    col_found = 1'b0;
    col_core  = '0;
    col_sel   = 1'b0;
    col_both  = 1'b0;
    for (int c = CORE_NUMBER - 1; c >= 0; c--) begin
      if (running && core_st[c] == C_BUSY && (core_inlier[c] || core_outlier[c]) &&
          (!sel_vec[c] || can_push)) begin
        col_found = 1'b1;
        col_core  = CORE_W'(c);
        col_sel   = sel_vec[c];
        col_both  = core_inlier[c] && core_outlier[c];
      end
    end
  end

  assign push     = col_found && col_sel;
  assign dispatch = running && (next_idx < size_q) && !req_out && free_found;
  assign rsp_fire = pt_rsp_valid && req_out;

  // Cache request/response and core-load outputs; the point bus is a
  // combinational pass-through of the response, zero when nothing loads.
  always_comb begin
    pt_req_valid = dispatch;
    pt_req_idx   = dispatch ? next_idx : '0;
    core_load    = rsp_fire ? (CORE_NUMBER'(1) << req_core) : '0;
    core_point_x = rsp_fire ? pt_rsp_x : '0;
    core_point_y = rsp_fire ? pt_rsp_y : '0;
    core_point_z = rsp_fire ? pt_rsp_z : '0;
  end

  assign out_valid  = !fifo_empty;
  assign out_idx    = fifo_empty ? '0 : fifo_mem[rd_ptr];
  assign busy       = (state == S_RUN) || (state == S_DRAIN);
  assign done       = (state == S_DONE);
  assign emit_count = emit_q;
  assign proto_err  = proto_q;

  // Run-level next state; start is only honoured from IDLE or DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = (point_cloud_size == '0) ? S_DONE : S_RUN;
      S_RUN:          if (completed == size_q) state_nxt = S_DRAIN;
      S_DRAIN:        if (fifo_empty) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Run state, request tracking and per-run counters.
  // NOTE: clocked state uses non-blocking assignments so every register sees
  // the pre-edge values of the others; blocking here would create order races.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      size_q    <= '0;
      next_idx  <= '0;
      completed <= '0;
      emit_q    <= '0;
      proto_q   <= 1'b0;
      req_out   <= 1'b0;
      req_core  <= '0;
      req_idx_q <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        size_q    <= point_cloud_size;
        next_idx  <= '0;
        completed <= '0;
        emit_q    <= '0;
        proto_q   <= 1'b0;
      end else begin
        if (dispatch) begin
          next_idx  <= next_idx + 1'b1;
          req_out   <= 1'b1;
          req_core  <= free_core;
          req_idx_q <= next_idx;
        end else if (rsp_fire) begin
          req_out <= 1'b0;
        end
        if (col_found) begin
          completed <= completed + 1'b1;
          if (push)     emit_q  <= emit_q + 1'b1;
          if (col_both) proto_q <= 1'b1;
        end
      end
    end
  end

  // Per-core lifecycle FREE -> RESERVED -> LOADED -> BUSY -> FREE; verdicts
  // are only looked at in BUSY, which blanks the cycle after the load.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CORE_NUMBER; c++) core_st[c] <= C_FREE;
    end else begin
      for (int c = 0; c < CORE_NUMBER; c++) begin
        case (core_st[c])
          C_FREE:     if (dispatch && free_core == CORE_W'(c)) core_st[c] <= C_RESERVED;
          C_RESERVED: if (rsp_fire && req_core == CORE_W'(c))  core_st[c] <= C_LOADED;
          C_LOADED:   core_st[c] <= C_BUSY;
          default:    if (col_found && col_core == CORE_W'(c)) core_st[c] <= C_FREE;
        endcase
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Index storage for cores and FIFO entries.
  // NOTE: storage arrays carry no reset; occupancy and core state already mark
  // every entry invalid, and a reset here would block RAM inference.
  always_ff @(posedge clock) begin
    if (rsp_fire) idx_buf[req_core] <= req_idx_q;
    if (push)     fifo_mem[wr_ptr]  <= idx_buf[col_core];
  end

endmodule

// File: tb/tb_dror_dispatch_controller.sv
// Self-checking bench: two controllers (emit outliers / emit inliers, 4-entry
// FIFO) share a cache model, core model and scoreboard selected by 'sel'.
module tb_dror_dispatch_controller;

  localparam int N = 16, CN = 4, IW = 32, FD = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, sel = 1'b0, out_ready = 1'b1;
  logic [IW-1:0] size_in = '0;
  logic rsp_valid = 1'b0;
  logic [N-1:0] rsp_x = '0, rsp_y = '0, rsp_z = '0;
  logic [CN-1:0] c_in = '0, c_out = '0;
  logic start0, start1;

  logic d0_req_valid, d0_ov, d0_busy, d0_done, d0_perr;
  logic d1_req_valid, d1_ov, d1_busy, d1_done, d1_perr;
  logic [IW-1:0] d0_req_idx, d0_oidx, d0_emit, d1_req_idx, d1_oidx, d1_emit;
  logic [CN-1:0] d0_load, d1_load;
  logic [N-1:0] d0_px, d0_py, d0_pz, d1_px, d1_py, d1_pz;

  logic m_req_valid, m_ov, m_busy, m_done, m_perr;
  logic [IW-1:0] m_req_idx, m_oidx, m_emit;
  logic [CN-1:0] m_load;
  logic [N-1:0] m_px, m_py, m_pz;

  assign start0 = start & ~sel;
  assign start1 = start & sel;
  assign m_req_valid = sel ? d1_req_valid : d0_req_valid;
  assign m_req_idx   = sel ? d1_req_idx   : d0_req_idx;
  assign m_load      = sel ? d1_load      : d0_load;
  assign m_px        = sel ? d1_px        : d0_px;
  assign m_py        = sel ? d1_py        : d0_py;
  assign m_pz        = sel ? d1_pz        : d0_pz;
  assign m_ov        = sel ? d1_ov        : d0_ov;
  assign m_oidx      = sel ? d1_oidx      : d0_oidx;
  assign m_busy      = sel ? d1_busy      : d0_busy;
  assign m_done      = sel ? d1_done      : d0_done;
  assign m_emit      = sel ? d1_emit      : d0_emit;
  assign m_perr      = sel ? d1_perr      : d0_perr;

  dror_dispatch_controller #(.N(N), .CORE_NUMBER(CN), .IDX_W(IW), .FIFO_DEPTH(FD), .MODE(0)) dut0 (
    .clock(clock), .reset(reset), .start(start0), .point_cloud_size(size_in),
    .pt_req_valid(d0_req_valid), .pt_req_idx(d0_req_idx), .pt_rsp_valid(rsp_valid),
    .pt_rsp_x(rsp_x), .pt_rsp_y(rsp_y), .pt_rsp_z(rsp_z), .core_load(d0_load),
    .core_point_x(d0_px), .core_point_y(d0_py), .core_point_z(d0_pz),
    .core_inlier(c_in), .core_outlier(c_out), .out_valid(d0_ov), .out_ready(out_ready),
    .out_idx(d0_oidx), .busy(d0_busy), .done(d0_done), .emit_count(d0_emit), .proto_err(d0_perr));

  dror_dispatch_controller #(.N(N), .CORE_NUMBER(CN), .IDX_W(IW), .FIFO_DEPTH(FD), .MODE(1)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .point_cloud_size(size_in),
    .pt_req_valid(d1_req_valid), .pt_req_idx(d1_req_idx), .pt_rsp_valid(rsp_valid),
    .pt_rsp_x(rsp_x), .pt_rsp_y(rsp_y), .pt_rsp_z(rsp_z), .core_load(d1_load),
    .core_point_x(d1_px), .core_point_y(d1_py), .core_point_z(d1_pz),
    .core_inlier(c_in), .core_outlier(c_out), .out_valid(d1_ov), .out_ready(out_ready),
    .out_idx(d1_oidx), .busy(d1_busy), .done(d1_done), .emit_count(d1_emit), .proto_err(d1_perr));

  always #5 clock = ~clock;

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Verdict table per point index: 0 inlier, 1 outlier, 2 both.
  logic [1:0] vtab [64];
  logic [IW-1:0] exp_q [$];
  bit sb_ordered = 1'b1;
  bit hold = 1'b0;
  int vlat = 2, rsp_dly = 0;

  // Cache model: answers each request after rsp_dly+1 cycles with x=idx,
  // y=idx+1, z=idx+2; checks indices are sequential and requested once.
  int req_count = 0, req_base = 0, run_id = 0, c_rdly = 0;
  bit c_pend = 1'b0;
  int seen_run [64];
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      c_pend    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (m_req_valid) begin
        check("req_once", seen_run[m_req_idx[5:0]] == run_id, 0);
        check("req_seq", m_req_idx, req_count - req_base);
        seen_run[m_req_idx[5:0]] <= run_id;
        req_count <= req_count + 1;
        c_pend    <= 1'b1;
        c_rdly    <= rsp_dly;
        rsp_x     <= m_req_idx[N-1:0];
        rsp_y     <= m_req_idx[N-1:0] + 16'd1;
        rsp_z     <= m_req_idx[N-1:0] + 16'd2;
      end else if (c_pend) begin
        if (c_rdly == 0) begin
          rsp_valid <= 1'b1;
          c_pend    <= 1'b0;
        end else begin
          c_rdly <= c_rdly - 1;
        end
      end
    end
  end

  // Core model: captures the index on core_load, raises the tabled verdict
  // vlat+1 cycles later (or when 'hold' drops) and pushes expected indices.
  int c_idx [CN];
  int c_cnt [CN] = '{default: -1};
  logic [CN-1:0] load_log [$];
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CN; c++) c_cnt[c] <= -1;
      c_in  <= '0;
      c_out <= '0;
    end else begin
      if (m_load != '0) begin
        check("load_onehot", $countones(m_load), 1);
        check("bus_x", m_px, rsp_x);
        check("bus_y", m_py, rsp_y);
        check("bus_z", m_pz, rsp_z);
        load_log.push_back(m_load);
      end
      for (int c = 0; c < CN; c++) begin
        if (m_load[c]) begin
          c_idx[c] <= int'(m_px);
          c_in[c]  <= 1'b0;
          c_out[c] <= 1'b0;
          c_cnt[c] <= vlat;
        end else if (c_cnt[c] > 0) begin
          c_cnt[c] <= c_cnt[c] - 1;
        end else if (c_cnt[c] == 0 && !hold) begin
          c_cnt[c] <= -1;
          c_in[c]  <= (vtab[c_idx[c][5:0]] != 2'd1);
          c_out[c] <= (vtab[c_idx[c][5:0]] != 2'd0);
          if (sel ? (vtab[c_idx[c][5:0]] == 2'd0) : (vtab[c_idx[c][5:0]] != 2'd0))
            exp_q.push_back(IW'(c_idx[c]));
        end
      end
    end
  end

  function automatic int find_exp(input logic [IW-1:0] v);
    for (int j = 0; j < exp_q.size(); j++) if (exp_q[j] == v) return j;
    return -1;
  endfunction

  // Output monitor: every accepted beat is matched against the scoreboard.
  int beats = 0;
  time beat_t [$];
  always @(negedge clock) begin
    if (reset && m_ov && out_ready) begin
      beats <= beats + 1;
      beat_t.push_back($time);
      if (exp_q.size() == 0) begin
        check("sb_unexpected", m_oidx, 64'hFFFF_FFFF_FFFF_FFFF);
      end else if (sb_ordered) begin
        check("sb_order", m_oidx, exp_q.pop_front());
      end else begin
        check("sb_member", find_exp(m_oidx) >= 0, 1);
        if (find_exp(m_oidx) >= 0) exp_q.delete(find_exp(m_oidx));
      end
    end
  end

  int beat_base = 0, log_base = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_run(input int sz, input logic s);
    sel       = s;
    size_in   = IW'(sz);
    run_id++;
    req_base  = req_count;
    beat_base = beats;
    log_base  = load_log.size();
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (!m_done && n < budget) begin
      tick();
      n++;
    end
    check(tag, m_done, 1);
  endtask

  task automatic set_vtab(input int lo, input int hi, input logic [1:0] v);
    for (int i = lo; i <= hi; i++) vtab[i] = v;
  endtask

  initial begin
    set_vtab(0, 63, 2'd0);
    #2 reset = 1'b0;
    tick();
    // Reset state
    check("rst_busy", m_busy, 0);
    check("rst_done", m_done, 0);
    check("rst_ov", m_ov, 0);
    check("rst_oidx", m_oidx, 0);
    check("rst_req", m_req_valid, 0);
    check("rst_load", m_load, 0);
    check("rst_emit", m_emit, 0);
    check("rst_perr", m_perr, 0);
    check("rst_d1_ov", d1_ov, 0);
    reset = 1'b1;
    tick();

    // Zero-size run: DONE one cycle after start, no requests
    check("z_pre_done", m_done, 0);
    start_run(0, 1'b0);
    check("z_done", m_done, 1);
    check("z_busy", m_busy, 0);
    check("z_req", m_req_valid, 0);
    repeat (3) tick();
    check("z_reqs", req_count - req_base, 0);

    // Basic: outliers at 2 and 5
    vtab[2] = 2'd1;
    vtab[5] = 2'd1;
    start_run(8, 1'b0);
    check("lat_req", m_req_valid, 1);
    check("lat_req_idx", m_req_idx, 0);
    check("basic_busy_run", m_busy, 1);
    wait_done(400, "basic_done");
    check("basic_emit", m_emit, 2);
    check("basic_beats", beats - beat_base, 2);
    check("basic_reqs", req_count - req_base, 8);
    check("basic_sb_empty", exp_q.size(), 0);
    check("basic_ov", m_ov, 0);
    check("basic_busy", m_busy, 0);
    check("basic_perr", m_perr, 0);

    // Mode: inlier-emitting controller, same verdicts
    start_run(8, 1'b1);
    wait_done(400, "mode_done");
    check("mode_emit", m_emit, 6);
    check("mode_beats", beats - beat_base, 6);
    check("mode_sb_empty", exp_q.size(), 0);

    // Backpressure: 4-entry FIFO, all outliers, sink stalled for 50 cycles
    set_vtab(0, 9, 2'd1);
    out_ready  = 1'b0;
    sb_ordered = 1'b0;
    start_run(10, 1'b0);
    repeat (50) tick();
    check("bp_emit", m_emit, 4);
    check("bp_reqs", req_count - req_base, 8);
    check("bp_ov", m_ov, 1);
    check("bp_busy", m_busy, 1);
    check("bp_beats", beats - beat_base, 0);
    out_ready = 1'b1;
    wait_done(400, "bp_done");
    check("bp_emit_all", m_emit, 10);
    check("bp_beats_all", beats - beat_base, 10);
    check("bp_sb_empty", exp_q.size(), 0);
    sb_ordered = 1'b1;

    // Simultaneous: all four cores raise verdicts on the same edge
    hold = 1'b1;
    start_run(6, 1'b0);
    repeat (20) tick();
    check("sim_reqs_held", req_count - req_base, 4);
    check("sim_first_load", load_log[log_base], 4'b0001);
    hold = 1'b0;
    wait_done(400, "sim_done");
    check("sim_beats", beats - beat_base, 6);
    check("sim_span", beat_t[beat_base + 3] - beat_t[beat_base], 30);
    check("sim_reload_core0", load_log[log_base + 4], 4'b0001);
    check("sim_sb_empty", exp_q.size(), 0);

    // Start while busy is ignored; inlier+outlier counts as outlier
    set_vtab(0, 9, 2'd0);
    vtab[1] = 2'd1;
    vtab[3] = 2'd2;
    start_run(6, 1'b0);
    repeat (3) tick();
    size_in = 2;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    check("ign_busy", m_busy, 1);
    wait_done(400, "ign_done");
    check("ign_reqs", req_count - req_base, 6);
    check("ign_emit", m_emit, 2);
    check("ign_beats", beats - beat_base, 2);
    check("perr_set", m_perr, 1);

    // Mid-run reset with three buffered entries
    set_vtab(0, 9, 2'd1);
    out_ready = 1'b0;
    start_run(10, 1'b0);
    check("perr_clear", m_perr, 0);
    for (int n = 0; n < 200 && m_emit != 3; n++) tick();
    check("rs_fill3", m_emit, 3);
    #2 reset = 1'b0;
    #1;
    check("rs_ov", m_ov, 0);
    check("rs_busy", m_busy, 0);
    check("rs_done", m_done, 0);
    check("rs_load", m_load, 0);
    check("rs_req", m_req_valid, 0);
    check("rs_emit", m_emit, 0);
    exp_q.delete();
    tick();
    reset     = 1'b1;
    out_ready = 1'b1;
    repeat (3) tick();
    check("rs_ov_after", m_ov, 0);
    check("rs_load_after", m_load, 0);
    set_vtab(0, 9, 2'd0);
    vtab[0] = 2'd1;
    vtab[4] = 2'd1;
    start_run(5, 1'b0);
    check("rs2_emit_start", m_emit, 0);
    wait_done(400, "rs2_done");
    check("rs2_emit", m_emit, 2);
    check("rs2_beats", beats - beat_base, 2);
    check("rs2_reqs", req_count - req_base, 5);
    check("rs2_sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
